cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- Coprocessor-0 register file for the 5-stage MIPS pipeline.
- Sits directly downstream of the write-back stage and consumes its wb_to_cp0 bus: commits exceptions and eret, and executes mtc0 writes.
- Serves mfc0 reads combinationally back to write-back.
- Runs the Count/Compare timer and produces the pending-interrupt flag that decode uses to tag an interrupt exception.

Parameters:
- CNT_DIV, 2, clk cycles per Count increment (1 or 2 legal).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wb_valid  in  1  bus qualifier; ex, eret and mtc0 are ignored when 0
- wb_to_cp0_bus  in  110  {ex[109], excode[108:104], badvaddr[103:72], bd[71], pc[70:39], mtc0_we[38], addr[37:33], wdata[32:1], eret[0]}
- ext_int  in  6  hardware interrupt lines, level-sensitive, already synchronous
- rd_addr  in  5  mfc0 read register number
- cp0_rdata  out  32  read data
- cp0_epc  out  32  current EPC, used as the eret target
- cp0_status_exl  out  1  Status.EXL
- int_pending  out  1  interrupt request to decode

Behaviour:
- Implemented registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14). Reads of any other number return 0; writes to them are dropped.
- Field commit qualifiers: ex_c = wb_valid&ex; eret_c = wb_valid&eret&~ex; wr_c = wb_valid&mtc0_we&~ex&~eret.
- Status layout:
  - [22] BEV is read-only 1.
  - [15:8] IM is R/W.
  - [1] EXL, [0] IE are R/W.
  - All other bits read 0.
  - Reset: 0x00400000.
- Cause layout:
  - [31] BD and [30] TI are read-only.
  - [15:10] IP7..IP2 are read-only hardware bits: IP7 = ext_int[5]|TI; IP6..IP2 = ext_int[4:0], sampled every cycle.
  - [9:8] IP1..IP0 are software-writable.
  - [6:2] ExcCode is read-only.
  - Reset: 0.
- Count:
  - Divider counter resets to 0 and increments Count on every CNT_DIV-th cycle.
  - wr_c to Count loads wdata, resets the divider, and takes priority over the increment.
  - Wraps 0xFFFFFFFF -> 0 with no flag.
  - Reset: Count = 0.
- Compare:
  - wr_c to Compare loads wdata and clears TI in the same edge.
  - TI is set on the edge after Count==Compare is observed, unless Compare is written that cycle.
  - TI stays set until Compare is written.
  - Compare = 0 at reset, but TI is not raised while reset is held.
- Exception commit (ex_c):
  - EXL <= 1 and ExcCode <= excode.
  - If EXL was 0: EPC <= bd ? pc-4 : pc, and BD <= bd.
  - If EXL was already 1: EPC and BD are unchanged.
  - If excode is AdEL(0x04) or AdES(0x05): BadVAddr <= badvaddr.
- eret_c: EXL <= 0; no other change.
- Simultaneous events:
  - ex beats eret, and eret beats mtc0.
  - A timer match coinciding with ex still sets TI.
- int_pending = |(Cause[15:8] & Status[15:8]) & IE & ~EXL. Combinational, no latency.
- Read and output timing:
  - cp0_rdata is a combinational mux on rd_addr over current register state. A write is visible the cycle after its edge; there is no write-to-read bypass.
  - cp0_epc and cp0_status_exl are direct register outputs.
- Reset values: cp0_epc = 0, cp0_status_exl = 0, int_pending = 0, BadVAddr = 0, EPC = 0.
- Reset mid-operation: all state including the divider returns to its reset value on the next edge; a pending ex in that cycle is discarded.

Decomposition:
- Shared header mycpu.h holds:
  - WB_TO_CP0_REGISTER_BUS_WD = 110.
  - CP0 register numbers CR_BADVADDR/COUNT/COMPARE/STATUS/CAUSE/EPC.
  - ExcCode constants EX_INT(0x00), EX_ADEL(0x04), EX_ADES(0x05), EX_SYS(0x08), EX_BP(0x09), EX_RI(0x0a), EX_OV(0x0c).
- One sub-module, cp0_timer:
  - Contains the divider, Count, Compare and TI.
  - Ports: clk, reset, count_we, compare_we, wdata; outputs count, compare, ti.

Test Plan:
- Reset, then read every register -> Status = 0x00400000, all others 0, int_pending = 0. After 10 cycles with CNT_DIV=2, Count = 5.
- ex, bd=1, pc=0xBFC00104, excode=0x0a, EXL=0 -> EPC = 0xBFC00100, Cause = 0x8000_0028, Status.EXL = 1. A second ex with bd=0, pc=0x200 -> EPC unchanged, ExcCode updated.
- ex with excode=0x04, badvaddr=0x1235 -> BadVAddr = 0x1235. ex with excode=0x0c -> BadVAddr unchanged.
- mtc0 Compare=8, mtc0 Count=0 -> TI = 1 on the edge after Count reaches 8. With Status = 0x00408001, int_pending = 1. mtc0 Compare=0x100 -> TI = 0 and int_pending = 0 the following cycle.
- mtc0 Cause=0x300 -> IP1..IP0 = 3, ExcCode unchanged. ext_int = 6'b000100 with IM4 = 1 and IE = 1 -> int_pending = 1 in the same cycle.
- In one beat, ex=1, eret=1, mtc0_we=1 (Status, wdata=0) -> only the exception commits: EXL = 1, Status.IM unchanged. With wb_valid=0 -> no state change at all.

Source files
------------

// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: write-back bus layout, CP0 register numbers and
// exception codes used by the pipeline.
package cp0_regfile_pkg;

  localparam int WB_TO_CP0_REGISTER_BUS_WD = 110;

  localparam logic [4:0] CR_BADVADDR = 5'd8;
  localparam logic [4:0] CR_COUNT    = 5'd9;
  localparam logic [4:0] CR_COMPARE  = 5'd11;
  localparam logic [4:0] CR_STATUS   = 5'd12;
  localparam logic [4:0] CR_CAUSE    = 5'd13;
  localparam logic [4:0] CR_EPC      = 5'd14;

  localparam logic [4:0] EX_INT  = 5'h00;
  localparam logic [4:0] EX_ADEL = 5'h04;
  localparam logic [4:0] EX_ADES = 5'h05;
  localparam logic [4:0] EX_SYS  = 5'h08;
  localparam logic [4:0] EX_BP   = 5'h09;
  localparam logic [4:0] EX_RI   = 5'h0a;
  localparam logic [4:0] EX_OV   = 5'h0c;

  // Field order matches the bus packing from bit 109 down to bit 0.
  typedef struct packed {
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic        bd;
    logic [31:0] pc;
    logic        mtc0_we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;
  } wb_to_cp0_t;

  function automatic logic is_addr_err(input logic [4:0] code);
    return (code == EX_ADEL) || (code == EX_ADES);
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: divided Count incrementer, Compare register and the
// sticky timer-interrupt flag TI.
module cp0_timer #(
  parameter int CNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [1:0]  div_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        ti_q;
  logic        tick;

  assign tick = (div_q == 2'(CNT_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      if (count_we) begin
        count_q <= wdata;
        div_q   <= '0;
      end else if (tick) begin
        count_q <= count_q + 32'd1;
        div_q   <= '0;
      end else begin
        div_q <= div_q + 2'd1;
      end
      // A Compare write both reloads the match value and acknowledges TI.
      if (compare_we) begin
        compare_q <= wdata;
        ti_q      <= 1'b0;
      end else if (count_q == compare_q) begin
        ti_q <= 1'b1;
      end
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: commits exceptions/eret and mtc0 from
// write-back, serves mfc0 reads and raises the pending-interrupt flag.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int CNT_DIV = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 wb_valid,
  input  logic [WB_TO_CP0_REGISTER_BUS_WD-1:0] wb_to_cp0_bus,
  input  logic [5:0]                           ext_int,
  input  logic [4:0]                           rd_addr,
  output logic [31:0]                          cp0_rdata,
  output logic [31:0]                          cp0_epc,
  output logic                                 cp0_status_exl,
  output logic                                 int_pending
);

  wb_to_cp0_t bus;
  logic ex_c, eret_c, wr_c;

  logic [31:0] badvaddr_q, epc_q;
  logic [7:0]  im_q;
  logic        exl_q, ie_q, bd_q;
  logic [4:0]  excode_q;
  logic [1:0]  ip_sw_q;

  logic [31:0] count, compare;
  logic        ti;
  logic [7:0]  ip;
  logic [31:0] status_w, cause_w;

  assign bus    = wb_to_cp0_bus;
  assign ex_c   = wb_valid & bus.ex;
  assign eret_c = wb_valid & bus.eret & ~bus.ex;
  assign wr_c   = wb_valid & bus.mtc0_we & ~bus.ex & ~bus.eret;

  cp0_timer #(.CNT_DIV(CNT_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (wr_c && bus.addr == CR_COUNT),
    .compare_we (wr_c && bus.addr == CR_COMPARE),
    .wdata      (bus.wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr_q <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      excode_q   <= '0;
      ip_sw_q    <= '0;
    end else if (ex_c) begin
      exl_q    <= 1'b1;
      excode_q <= bus.excode;
      // Nested exceptions keep the outermost return point.
      if (!exl_q) begin
        epc_q <= bus.bd ? bus.pc - 32'd4 : bus.pc;
        bd_q  <= bus.bd;
      end
      if (is_addr_err(bus.excode)) badvaddr_q <= bus.badvaddr;
    end else if (eret_c) begin
      exl_q <= 1'b0;
    end else if (wr_c) begin
      case (bus.addr)
        CR_STATUS: begin
          im_q  <= bus.wdata[15:8];
          exl_q <= bus.wdata[1];
          ie_q  <= bus.wdata[0];
        end
        CR_CAUSE: ip_sw_q <= bus.wdata[9:8];
        CR_EPC:   epc_q   <= bus.wdata;
        default: ;
      endcase
    end
  end

  // Hardware pending bits follow the lines directly, so a level change is
  // seen by decode in the same cycle.
  assign ip       = {ext_int[5] | ti, ext_int[4:0], ip_sw_q};
  assign status_w = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_w  = {bd_q, ti, 14'd0, ip, 1'b0, excode_q, 2'd0};

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cp0_rdata = '0;
    case (rd_addr)
      CR_BADVADDR: cp0_rdata = badvaddr_q;
      CR_COUNT:    cp0_rdata = count;
      CR_COMPARE:  cp0_rdata = compare;
      CR_STATUS:   cp0_rdata = status_w;
      CR_CAUSE:    cp0_rdata = cause_w;
      CR_EPC:      cp0_rdata = epc_q;
      default:     cp0_rdata = '0;
    endcase
  end

  assign cp0_epc        = epc_q;
  assign cp0_status_exl = exl_q;
  assign int_pending    = (|(ip & im_q)) & ie_q & ~exl_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomised bench for cp0_regfile: a word-level CP0 model predicts every
// cycle's outputs, a monitor process compares them against the DUT.
module tb_cp0_regfile;
  import cp0_regfile_pkg::*;

  localparam int CNT_DIV = 2;

  logic        clk = 1'b0;
  logic        reset, wb_valid;
  wb_to_cp0_t  bus;
  logic [5:0]  ext_int;
  logic [4:0]  rd_addr;
  logic [31:0] cp0_rdata, cp0_epc;
  logic        cp0_status_exl, int_pending;

  cp0_regfile #(.CNT_DIV(CNT_DIV)) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_valid       (wb_valid),
    .wb_to_cp0_bus  (bus),
    .ext_int        (ext_int),
    .rd_addr        (rd_addr),
    .cp0_rdata      (cp0_rdata),
    .cp0_epc        (cp0_epc),
    .cp0_status_exl (cp0_status_exl),
    .int_pending    (int_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [31:0] epc;
    logic        exl;
    logic        ip;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   beat_no = 0;
  bit   stim_done = 1'b0;

  // Reference state, held as architectural values.
  logic [31:0] m_badvaddr, m_count, m_compare, m_epc;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [4:0]  m_excode;
  logic [1:0]  m_sw;
  int          m_cycles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status_word();
    return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
  endfunction

  function automatic logic [31:0] m_cause_word(input logic [5:0] ext);
    logic [31:0] hw;
    hw = 32'(ext) | (32'(m_ti) << 5);
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (hw << 10) | (32'(m_sw) << 8) | (32'(m_excode) << 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [5:0] ext);
    case (a)
      5'd8:    return m_badvaddr;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status_word();
      5'd13:   return m_cause_word(ext);
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_int(input logic [5:0] ext);
    logic [31:0] pend;
    pend = (m_cause_word(ext) >> 8) & (m_status_word() >> 8) & 32'hff;
    return (pend != 0) && m_ie && !m_exl;
  endfunction

  function automatic void m_step(input logic rst, input logic v, input wb_to_cp0_t b);
    logic ex_c, eret_c, wr_c, new_ti;
    if (rst) begin
      m_badvaddr = 0; m_count = 0; m_compare = 0; m_epc = 0;
      m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0;
      m_excode = 0; m_sw = 0; m_cycles = 0;
      return;
    end
    ex_c   = v && b.ex;
    eret_c = v && b.eret && !b.ex;
    wr_c   = v && b.mtc0_we && !b.ex && !b.eret;
    new_ti = m_ti || (m_count == m_compare);
    if (wr_c && b.addr == 5'd11) begin
      new_ti = 0;
      m_compare = b.wdata;
    end
    if (wr_c && b.addr == 5'd9) begin
      m_count = b.wdata;
      m_cycles = 0;
    end else begin
      m_cycles++;
      if (m_cycles % CNT_DIV == 0) m_count = m_count + 1;
    end
    m_ti = new_ti;
    if (ex_c) begin
      if (!m_exl) begin
        m_epc = b.bd ? b.pc - 4 : b.pc;
        m_bd  = b.bd;
      end
      m_exl = 1;
      m_excode = b.excode;
      if (b.excode == 5'h04 || b.excode == 5'h05) m_badvaddr = b.badvaddr;
    end else if (eret_c) begin
      m_exl = 0;
    end else if (wr_c) begin
      if (b.addr == 5'd12) begin
        m_im = b.wdata[15:8]; m_exl = b.wdata[1]; m_ie = b.wdata[0];
      end else if (b.addr == 5'd13) begin
        m_sw = b.wdata[9:8];
      end else if (b.addr == 5'd14) begin
        m_epc = b.wdata;
      end
    end
  endfunction

  // One clock of stimulus, entered and left on a falling edge.
  task automatic beat(input logic rst, input logic v, input wb_to_cp0_t b,
                      input logic [5:0] ext, input logic [4:0] rd, input bit chk);
    exp_t e;
    reset = rst; wb_valid = v; bus = b; ext_int = ext; rd_addr = rd;
    beat_no++;
    if (chk) begin
      e.idx = beat_no; e.rd = rd; e.rdata = m_read(rd, ext);
      e.epc = m_epc; e.exl = m_exl; e.ip = m_int(ext);
      exp_q.push_back(e);
    end
    m_step(rst, v, b);
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] rd, input logic [5:0] ext = 6'd0);
    beat(1'b0, 1'b0, '0, ext, rd, 1'b1);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d, input logic [4:0] rd);
    wb_to_cp0_t b;
    b = '0; b.mtc0_we = 1; b.addr = a; b.wdata = d;
    beat(1'b0, 1'b1, b, 6'd0, rd, 1'b1);
  endtask

  task automatic exc(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                     input logic [31:0] badv, input logic [4:0] rd);
    wb_to_cp0_t b;
    b = '0; b.ex = 1; b.excode = code; b.bd = bd; b.pc = pc; b.badvaddr = badv;
    beat(1'b0, 1'b1, b, 6'd0, rd, 1'b1);
  endtask

  // Monitor: compares the entry for the current cycle once inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("rdata[beat %0d rd %0d]", e.idx, e.rd), cp0_rdata, e.rdata);
        check($sformatf("epc[beat %0d]", e.idx), cp0_epc, e.epc);
        check($sformatf("exl[beat %0d]", e.idx), 32'(cp0_status_exl), 32'(e.exl));
        check($sformatf("int_pending[beat %0d]", e.idx), 32'(int_pending), 32'(e.ip));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_to_cp0_t b;
    logic [4:0] addrs [8];
    addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd3, 5'd31};
    reset = 1; wb_valid = 0; bus = '0; ext_int = 0; rd_addr = 0;
    @(negedge clk);
    beat(1'b1, 1'b0, '0, 6'd0, 5'd0, 1'b0);
    beat(1'b1, 1'b0, '0, 6'd0, 5'd12, 1'b1);
    beat(1'b1, 1'b0, '0, 6'd0, 5'd13, 1'b1);

    // Post-reset register sweep, then Count after ten edges.
    foreach (addrs[i]) idle(addrs[i]);
    idle(5'd8);
    idle(5'd9);
    idle(5'd9);
    idle(5'd9);

    // Park Compare far away so TI is clear for the exception checks.
    mtc0(CR_COMPARE, 32'hFFFF_0000, 5'd13);
    exc(EX_RI, 1'b1, 32'hBFC0_0104, 32'h0, 5'd14);
    idle(5'd14); idle(5'd13); idle(5'd12);
    exc(EX_SYS, 1'b0, 32'h0000_0200, 32'h0, 5'd13);
    idle(5'd14); idle(5'd13);
    exc(EX_ADEL, 1'b0, 32'h0000_0300, 32'h0000_1235, 5'd8);
    idle(5'd8);
    exc(EX_OV, 1'b0, 32'h0000_0400, 32'h0000_9999, 5'd8);
    idle(5'd8); idle(5'd13);

    // Timer interrupt through IM7.
    b = '0; b.eret = 1;
    beat(1'b0, 1'b1, b, 6'd0, 5'd12, 1'b1);
    mtc0(CR_STATUS, 32'h0040_8001, 5'd12);
    mtc0(CR_COMPARE, 32'd8, 5'd11);
    mtc0(CR_COUNT, 32'd0, 5'd9);
    repeat (22) idle(5'd13);
    mtc0(CR_COMPARE, 32'h100, 5'd13);
    idle(5'd13); idle(5'd13);

    // Software bits and an external line through IM4.
    mtc0(CR_CAUSE, 32'h0000_0300, 5'd13);
    idle(5'd13);
    mtc0(CR_STATUS, 32'h0040_1001, 5'd12);
    idle(5'd12, 6'b000100);
    idle(5'd13, 6'b000100);
    idle(5'd13, 6'b000000);

    // ex beats eret beats mtc0; then the same beat with no qualifier.
    b = '0; b.ex = 1; b.eret = 1; b.mtc0_we = 1; b.addr = CR_STATUS; b.excode = EX_BP;
    b.pc = 32'h0000_0500;
    beat(1'b0, 1'b1, b, 6'd0, 5'd12, 1'b1);
    idle(5'd12); idle(5'd13);
    b.excode = EX_ADES; b.badvaddr = 32'hDEAD_0000; b.addr = CR_EPC; b.wdata = 32'h1111_2222;
    beat(1'b0, 1'b0, b, 6'd0, 5'd8, 1'b1);
    idle(5'd8); idle(5'd14); idle(5'd12);

    // Randomised traffic, including occasional mid-operation resets.
    for (int n = 0; n < 3000; n++) begin
      logic rst, v;
      logic [5:0] ext;
      logic [4:0] rd;
      rst = ($urandom % 100) == 0;
      v   = ($urandom % 4) != 0;
      b = '0;
      b.ex       = ($urandom % 8) == 0;
      b.eret     = ($urandom % 8) == 0;
      b.mtc0_we  = ($urandom % 3) == 0;
      b.excode   = ($urandom % 2) ? 5'($urandom % 6) : 5'($urandom);
      b.badvaddr = $urandom;
      b.bd       = 1'($urandom);
      b.pc       = $urandom;
      b.addr     = ($urandom % 4) == 0 ? 5'($urandom) : addrs[$urandom % 5];
      if (b.addr == CR_BADVADDR) b.addr = 5'd7;
      b.wdata    = $urandom;
      if (b.addr == CR_COMPARE && ($urandom % 2)) b.wdata = m_count + 32'($urandom % 8);
      ext = ($urandom % 2) ? 6'($urandom) : 6'd0;
      rd  = ($urandom % 4) == 0 ? 5'($urandom) : addrs[$urandom % 5];
      beat(rst, v, b, ext, rd, 1'b1);
    end

    reset = 0; wb_valid = 0; bus = '0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #5;
    if (exp_q.size() > 0) check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
